bresenham_draw: RTL and testbench



---
 rtl/bresenham_draw.sv | 150 +++++++++++++++
 tb/tb_bresenham_draw.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bresenham_draw.sv
// Line rasteriser: latches one signed segment per go pulse and walks it with
// integer Bresenham, emitting one in-frame pixel per accepted valid/ready handshake.
module bresenham_draw #(
  parameter int OUT_WIDTH  = 8,
  parameter int BRES_WIDTH = OUT_WIDTH + 1,
  parameter int FRAME_MIN  = 0,
  parameter int FRAME_MAX  = 255,
  parameter int ERR_WIDTH  = BRES_WIDTH + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  input  logic signed [BRES_WIDTH-1:0] stax,
  input  logic signed [BRES_WIDTH-1:0] stay,
  input  logic signed [BRES_WIDTH-1:0] endx,
  input  logic signed [BRES_WIDTH-1:0] endy,
  input  logic                         pix_ready,
  output logic                         pix_valid,
  output logic [OUT_WIDTH-1:0]         pix_x,
  output logic [OUT_WIDTH-1:0]         pix_y,
  output logic                         busy,
  output logic                         done
);

  typedef logic signed [ERR_WIDTH-1:0] coord_t;
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_DRAW, S_DONE} state_t;

  localparam coord_t F_MIN = coord_t'(FRAME_MIN);
  localparam coord_t F_MAX = coord_t'(FRAME_MAX);
  localparam coord_t ONE   = coord_t'(1);

  state_t r_state;
  coord_t r_x0, r_y0, r_x1, r_y1;
  coord_t r_dx, r_dy, r_err;
  coord_t r_cur_x, r_cur_y;
  logic   r_sx_neg, r_sy_neg;

  function automatic coord_t sext(input logic signed [BRES_WIDTH-1:0] v);
    return coord_t'(v);
  endfunction

  function automatic logic in_frame(input coord_t v);
    return (v >= F_MIN) && (v <= F_MAX);
  endfunction

  // Segment geometry, consumed only in INIT.
  coord_t w_ddx, w_ddy, w_adx, w_ady;
  assign w_ddx = r_x1 - r_x0;
  assign w_ddy = r_y1 - r_y0;
  assign w_adx = (w_ddx < 0) ? -w_ddx : w_ddx;
  assign w_ady = (w_ddy < 0) ? -w_ddy : w_ddy;

  // One extra bit so 2*err cannot wrap for the widest segments.
  logic signed [ERR_WIDTH:0] w_e2, w_dx_w, w_dy_w;
  assign w_e2   = {r_err, 1'b0};
  assign w_dx_w = {r_dx[ERR_WIDTH-1], r_dx};
  assign w_dy_w = {r_dy[ERR_WIDTH-1], r_dy};

  logic w_step, w_at_end;
  assign w_step   = pix_ready | ~pix_valid;
  assign w_at_end = (r_cur_x == r_x1) && (r_cur_y == r_y1);

  coord_t w_err_nxt, w_x_nxt, w_y_nxt;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_err_nxt = r_err;
    w_x_nxt   = r_cur_x;
    w_y_nxt   = r_cur_y;
    if (w_e2 >= w_dy_w) begin
      w_err_nxt = w_err_nxt + r_dy;
      w_x_nxt   = r_cur_x + (r_sx_neg ? -ONE : ONE);
    end
    if (w_e2 <= w_dx_w) begin
      w_err_nxt = w_err_nxt + r_dx;
      w_y_nxt   = r_cur_y + (r_sy_neg ? -ONE : ONE);
    end
  end

  // NOTE: state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_x0      <= '0;
      r_y0      <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_err     <= '0;
      r_cur_x   <= '0;
      r_cur_y   <= '0;
      r_sx_neg  <= 1'b0;
      r_sy_neg  <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_x0    <= sext(stax);
            r_y0    <= sext(stay);
            r_x1    <= sext(endx);
            r_y1    <= sext(endy);
            busy    <= 1'b1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_dx      <= w_adx;
          r_dy      <= -w_ady;
          r_err     <= w_adx - w_ady;
          r_sx_neg  <= !(r_x0 < r_x1);
          r_sy_neg  <= !(r_y0 < r_y1);
          r_cur_x   <= r_x0;
          r_cur_y   <= r_y0;
          pix_valid <= in_frame(r_x0) && in_frame(r_y0);
          pix_x     <= r_x0[OUT_WIDTH-1:0];
          pix_y     <= r_y0[OUT_WIDTH-1:0];
          r_state   <= S_DRAW;
        end
        S_DRAW: begin
          if (w_step) begin
            if (w_at_end) begin
              pix_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_err     <= w_err_nxt;
              r_cur_x   <= w_x_nxt;
              r_cur_y   <= w_y_nxt;
              pix_valid <= in_frame(w_x_nxt) && in_frame(w_y_nxt);
              pix_x     <= w_x_nxt[OUT_WIDTH-1:0];
              pix_y     <= w_y_nxt[OUT_WIDTH-1:0];
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_draw.sv
// Scoreboard bench for bresenham_draw: stimulus pushes hand-computed pixels and
// done markers into queues; negedge monitors pop and compare on each handshake.
module tb_bresenham_draw;
  localparam int OW = 8;
  localparam int BW = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic go = 1'b0, go2 = 1'b0;
  logic ready = 1'b1, ready2 = 1'b1;
  logic signed [BW-1:0] stax = '0, stay = '0, endx = '0, endy = '0;

  logic          pix_valid, busy, done;
  logic [OW-1:0] pix_x, pix_y;
  logic          pix_valid2, busy2, done2;
  logic [OW-1:0] pix_x2, pix_y2;

  bresenham_draw u_dut (
    .clk(clk), .rst(rst), .go(go),
    .stax(stax), .stay(stay), .endx(endx), .endy(endy),
    .pix_ready(ready), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .done(done)
  );

  bresenham_draw #(.FRAME_MAX(2)) u_clip (
    .clk(clk), .rst(rst), .go(go2),
    .stax(stax), .stay(stay), .endx(endx), .endy(endy),
    .pix_ready(ready2), .pix_valid(pix_valid2), .pix_x(pix_x2), .pix_y(pix_y2),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_done; int x; int y;} exp_t;
  exp_t q1[$];
  exp_t q2[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit sb_ignore = 1'b0;
  bit bp_mode   = 1'b0;
  int cyc       = 0;

  task automatic check(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic push_px(input int x, input int y, input bit clip);
    exp_t e;
    e.is_done = 1'b0; e.x = x; e.y = y;
    if (clip) q2.push_back(e); else q1.push_back(e);
  endtask

  task automatic push_done(input bit clip);
    exp_t e;
    e.is_done = 1'b1; e.x = 0; e.y = 0;
    if (clip) q2.push_back(e); else q1.push_back(e);
  endtask

  // Ready pattern 1,0,0 repeating under backpressure, otherwise held high.
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
  end

  // Main DUT monitor: hold check under backpressure plus scoreboard pops.
  bit prev_hold = 1'b0;
  int prev_xy   = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (prev_hold)
        check("hold", pix_valid && int'({pix_x, pix_y}) == prev_xy,
              int'({pix_valid, pix_x, pix_y}), prev_xy | 32'h10000);
      if (pix_valid && ready && !sb_ignore) begin
        if (q1.size() == 0) check("px_unexpected", 1'b0, int'({pix_x, pix_y}), -1);
        else begin
          e = q1.pop_front();
          check("pixel", !e.is_done && int'(pix_x) == e.x && int'(pix_y) == e.y,
                int'({pix_x, pix_y}), e.is_done ? -1 : e.x * 256 + e.y);
        end
      end
      if (done) begin
        if (q1.size() == 0) check("done_unexpected", 1'b0, 1, 0);
        else begin
          e = q1.pop_front();
          check("done_order", e.is_done, 1, e.is_done ? 1 : e.x * 256 + e.y);
        end
      end
      prev_hold = pix_valid && !ready;
      prev_xy   = int'({pix_x, pix_y});
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Clipping DUT monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (pix_valid2 && ready2) begin
        if (q2.size() == 0) check("clip_px_unexpected", 1'b0, int'({pix_x2, pix_y2}), -1);
        else begin
          e = q2.pop_front();
          check("clip_pixel", !e.is_done && int'(pix_x2) == e.x && int'(pix_y2) == e.y,
                int'({pix_x2, pix_y2}), e.is_done ? -1 : e.x * 256 + e.y);
        end
      end
      if (done2) begin
        if (q2.size() == 0) check("clip_done_unexpected", 1'b0, 1, 0);
        else begin
          e = q2.pop_front();
          check("clip_done_order", e.is_done, 1, 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_seg(input int ax, input int ay, input int bx, input int by,
                         input bit timed, input bit inject_go, input bit go_at_done);
    int adx, ady, len, first_v, done_k, busy_n;
    adx = (bx > ax) ? bx - ax : ax - bx;
    ady = (by > ay) ? by - ay : ay - by;
    len = ((adx > ady) ? adx : ady) + 1;
    @(posedge clk); #1;
    go = 1'b1;
    stax = BW'(ax); stay = BW'(ay); endx = BW'(bx); endy = BW'(by);
    @(posedge clk); #1;
    go = 1'b0;
    stax = -9'sd1; stay = -9'sd1; endx = -9'sd1; endy = -9'sd1;
    first_v = -1; done_k = -1; busy_n = 0;
    for (int k = 1; k <= 400 && done_k < 0; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (pix_valid && first_v < 0) first_v = k;
      if (done) done_k = k;
      if (inject_go && k == 3) begin
        go = 1'b1; stax = 9'sd100; stay = 9'sd100; endx = 9'sd100; endy = 9'sd100;
      end
      if (inject_go && k == 4) go = 1'b0;
      if (go_at_done && done) begin
        go = 1'b1; stax = 9'sd50; stay = 9'sd50; endx = 9'sd60; endy = 9'sd60;
      end
    end
    check("done_seen", done_k > 0, done_k, 1);
    if (timed) begin
      check("first_valid_latency", first_v == 2, first_v, 2);
      check("done_latency", done_k == 2 + len, done_k, 2 + len);
      check("busy_cycles", busy_n == len + 1, busy_n, len + 1);
    end
    if (go_at_done) begin
      @(negedge clk);
      check("go_in_done_ignored", !busy && !pix_valid, int'({busy, pix_valid}), 0);
      go = 1'b0;
    end
  endtask

  initial begin
    int clip_done_k, clip_valid_n;
    bit bad;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", !busy, busy, 0);
    check("rst_valid", !pix_valid, pix_valid, 0);
    check("rst_done", !done, done, 0);
    check("rst_pix", pix_x == 0 && pix_y == 0, int'({pix_x, pix_y}), 0);
    check("rst_clip_busy", !busy2 && !pix_valid2, int'({busy2, pix_valid2}), 0);
    rst = 1'b1;

    // Horizontal.
    for (int x = 0; x <= 4; x++) push_px(x, 0, 0);
    push_done(0);
    run_seg(0, 0, 4, 0, 1, 0, 0);

    // Steep, with a stray go mid-segment.
    push_px(10, 10, 0); push_px(10, 11, 0); push_px(11, 12, 0);
    push_px(11, 13, 0); push_px(12, 14, 0); push_px(12, 15, 0);
    push_done(0);
    run_seg(10, 10, 12, 15, 1, 1, 0);

    // Reverse, with go asserted during the done cycle.
    for (int x = 20; x >= 17; x--) push_px(x, 5, 0);
    push_done(0);
    run_seg(20, 5, 17, 5, 1, 0, 1);

    // Zero-length segment.
    push_px(7, 7, 0);
    push_done(0);
    run_seg(7, 7, 7, 7, 1, 0, 0);

    // Diagonal under backpressure.
    bp_mode = 1'b1;
    for (int i = 0; i <= 3; i++) push_px(i, i, 0);
    push_done(0);
    run_seg(0, 0, 3, 3, 0, 0, 0);
    bp_mode = 1'b0;

    // Clipping: x=3,4 are walked without stalling but never presented.
    for (int x = 0; x <= 2; x++) push_px(x, 0, 1);
    push_done(1);
    @(posedge clk); #1;
    go2 = 1'b1; stax = 9'sd0; stay = 9'sd0; endx = 9'sd4; endy = 9'sd0;
    @(posedge clk); #1;
    go2 = 1'b0;
    clip_done_k = -1; clip_valid_n = 0;
    for (int k = 1; k <= 100 && clip_done_k < 0; k++) begin
      @(negedge clk);
      if (pix_valid2) clip_valid_n++;
      if (done2) clip_done_k = k;
    end
    check("clip_done_latency", clip_done_k == 7, clip_done_k, 7);
    check("clip_valid_cycles", clip_valid_n == 3, clip_valid_n, 3);

    // Reset mid-segment.
    sb_ignore = 1'b1;
    @(posedge clk); #1;
    go = 1'b1; stax = 9'sd0; stay = 9'sd0; endx = 9'sd10; endy = 9'sd0;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", busy, busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle", !busy && !pix_valid && !done, int'({busy, pix_valid, done}), 0);
    rst = 1'b1;
    bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) bad = 1'b1;
    end
    check("abort_no_done", !bad, bad, 0);
    sb_ignore = 1'b0;

    // Fresh segment after the abort.
    for (int x = 0; x <= 4; x++) push_px(x, 0, 0);
    push_done(0);
    run_seg(0, 0, 4, 0, 1, 0, 0);

    repeat (3) @(negedge clk);
    check("q1_drained", q1.size() == 0, q1.size(), 0);
    check("q2_drained", q2.size() == 0, q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
